frv_axi_sram: RTL



---
 rtl/frv_axi_pkg.sv | 32 +++
 rtl/frv_axi_sram.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/frv_axi_pkg.sv
// rtl/frv_axi_pkg.sv - shared AXI4-Lite response codes, SRAM bridge states and window check
package frv_axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_HALF  = 3'd1,
        ST_WR_MEM   = 3'd2,
        ST_WR_RSP   = 3'd3,
        ST_RD_MEM   = 3'd4,
        ST_RD_LATCH = 3'd5,
        ST_RD_RSP   = 3'd6
    } frv_axi_state_t;

    // 33-bit compare so a window whose top is exactly 2^32 does not wrap.
    function automatic logic axi_in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] size
    );
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + {1'b0, size};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/frv_axi_sram.sv
// rtl/frv_axi_sram.sv - AXI4-Lite slave serialising one transaction at a time onto a
// single-port synchronous SRAM, with SLVERR for accesses outside the memory window.
module frv_axi_sram
    import frv_axi_pkg::*;
#(
    parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
    parameter logic [31:0] MEM_SIZE    = 32'h0001_0000,
    parameter logic        WR_PRIORITY = 1'b1,
    localparam int         AW          = $clog2(MEM_SIZE / 4)
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          axi_awvalid,
    output logic          axi_awready,
    input  logic [31:0]   axi_awaddr,
    input  logic [2:0]    axi_awprot,
    input  logic          axi_wvalid,
    output logic          axi_wready,
    input  logic [31:0]   axi_wdata,
    input  logic [3:0]    axi_wstrb,
    output logic          axi_bvalid,
    input  logic          axi_bready,
    output logic [1:0]    axi_bresp,
    input  logic          axi_arvalid,
    output logic          axi_arready,
    input  logic [31:0]   axi_araddr,
    input  logic [2:0]    axi_arprot,
    output logic          axi_rvalid,
    input  logic          axi_rready,
    output logic [31:0]   axi_rdata,
    output logic [1:0]    axi_rresp,
    output logic          sram_cen,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    output logic [3:0]    sram_wstrb,
    input  logic [31:0]   sram_rdata
);

    frv_axi_state_t state;

    logic        aw_got;
    logic        w_got;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        is_idle;
    logic        is_half;
    logic        wr_pend;
    logic        wr_sel;
    logic        rd_sel;
    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        wr_both;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        wr_ok;
    logic        rd_ok;
    logic [31:0] wr_off;
    logic [31:0] rd_off;
    logic        unused_ok;

    assign is_idle = (state == ST_IDLE);
    assign is_half = (state == ST_WR_HALF);

    assign wr_pend = axi_awvalid | axi_wvalid;
    assign wr_sel  = wr_pend & (WR_PRIORITY | ~axi_arvalid);
    assign rd_sel  = axi_arvalid & ~wr_sel;

    assign axi_awready = (is_idle & wr_sel) | (is_half & ~aw_got);
    assign axi_wready  = (is_idle & wr_sel) | (is_half & ~w_got);
    assign axi_arready = is_idle & rd_sel;

    assign aw_hs = axi_awvalid & axi_awready;
    assign w_hs  = axi_wvalid & axi_wready;
    assign ar_hs = axi_arvalid & axi_arready;

    // The half that completes this cycle is used directly so the SRAM cycle follows at once.
    assign wr_both = (aw_got | aw_hs) & (w_got | w_hs);
    assign wr_addr = aw_hs ? axi_awaddr : awaddr_q;
    assign wr_data = w_hs ? axi_wdata : wdata_q;
    assign wr_strb = w_hs ? axi_wstrb : wstrb_q;

    assign wr_ok  = axi_in_range(wr_addr, MEM_BASE, MEM_SIZE);
    assign rd_ok  = axi_in_range(axi_araddr, MEM_BASE, MEM_SIZE);
    assign wr_off = wr_addr - MEM_BASE;
    assign rd_off = axi_araddr - MEM_BASE;

    assign sram_cen   = (state == ST_WR_MEM) | (state == ST_RD_MEM);
    assign sram_wen   = (state == ST_WR_MEM);
    assign axi_bvalid = (state == ST_WR_RSP);
    assign axi_rvalid = (state == ST_RD_RSP);

    assign unused_ok = ^{axi_awprot, axi_arprot, wr_off[31:AW+2], wr_off[1:0],
                         rd_off[31:AW+2], rd_off[1:0]};

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state      <= ST_IDLE;
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            axi_bresp  <= '0;
            axi_rresp  <= '0;
            axi_rdata  <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_wstrb <= '0;
        end else begin
            if (aw_hs) begin
                aw_got   <= 1'b1;
                awaddr_q <= axi_awaddr;
            end
            if (w_hs) begin
                w_got   <= 1'b1;
                wdata_q <= axi_wdata;
                wstrb_q <= axi_wstrb;
            end
            case (state)
                ST_IDLE, ST_WR_HALF: begin
                    if (ar_hs) begin
                        if (rd_ok) begin
                            state     <= ST_RD_MEM;
                            sram_addr <= rd_off[AW+1:2];
                        end else begin
                            state     <= ST_RD_RSP;
                            axi_rdata <= '0;
                            axi_rresp <= AXI_RESP_SLVERR;
                        end
                    end else if (aw_hs || w_hs || is_half) begin
                        if (wr_both) begin
                            aw_got <= 1'b0;
                            w_got  <= 1'b0;
                            if (wr_ok) begin
                                state      <= ST_WR_MEM;
                                sram_addr  <= wr_off[AW+1:2];
                                sram_wdata <= wr_data;
                                sram_wstrb <= wr_strb;
                            end else begin
                                state     <= ST_WR_RSP;
                                axi_bresp <= AXI_RESP_SLVERR;
                            end
                        end else begin
                            state <= ST_WR_HALF;
                        end
                    end
                end
                ST_WR_MEM: begin
                    state     <= ST_WR_RSP;
                    axi_bresp <= AXI_RESP_OKAY;
                end
                ST_WR_RSP: begin
                    if (axi_bready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RD_MEM: begin
                    state <= ST_RD_LATCH;
                end
                ST_RD_LATCH: begin
                    state     <= ST_RD_RSP;
                    axi_rdata <= sram_rdata;
                    axi_rresp <= AXI_RESP_OKAY;
                end
                ST_RD_RSP: begin
                    if (axi_rready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
